// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared constants, dispatcher state and job type for the GCD feeder
package gcd_pkg;

    localparam int GCD_WIDTH = 32;
    localparam int GCD_TAG_W = 4;
    localparam int GCD_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } disp_state_e;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
        logic [GCD_TAG_W-1:0] tag;
    } gcd_job_t;

endpackage

// File: rtl/gcd_dispatch_if.sv
// rtl/gcd_dispatch_if.sv - job input stream, result output stream and engine link
interface gcd_dispatch_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int TAG_W = GCD_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_bypass;

    logic             eng_start;
    logic [WIDTH-1:0] eng_a;
    logic [WIDTH-1:0] eng_b;
    logic             eng_ready;
    logic             eng_done_tick;
    logic [WIDTH-1:0] eng_r;

    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
               eng_ready, eng_done_tick, eng_r,
        input  in_ready, out_valid, out_r, out_tag, out_bypass,
               eng_start, eng_a, eng_b, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
               eng_ready, eng_done_tick, eng_r,
        output in_ready, out_valid, out_r, out_tag, out_bypass,
               eng_start, eng_a, eng_b, busy
    );

endinterface

// File: rtl/gcd_job_fifo.sv
// rtl/gcd_job_fifo.sv - first-word-fall-through job FIFO with full/empty flags
module gcd_job_fifo #(
    parameter int DATA_W = 68,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/gcd_dispatch.sv
// rtl/gcd_dispatch.sv - feeds queued jobs to the GCD engine and returns results in order
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = GCD_DEPTH,
    parameter int TAG_W = GCD_TAG_W
) (
    input  logic         clk,
    input  logic         reset_n,
    gcd_dispatch_if.slave bus
);
    localparam int JOB_W = 2*WIDTH + TAG_W;

    disp_state_e      state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_r_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_bypass_q;
    logic             eng_start_q;
    logic [WIDTH-1:0] eng_a_q;
    logic [WIDTH-1:0] eng_b_q;
    logic [TAG_W-1:0] tag_q;

    logic [JOB_W-1:0] head;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [TAG_W-1:0] head_tag;
    logic             fifo_full;
    logic             fifo_empty;
    logic             slot_free;
    logic             dispatch;
    logic             head_zero;

    gcd_job_fifo #(
        .DATA_W (JOB_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (bus.in_valid),
        .din   ({bus.in_a, bus.in_b, bus.in_tag}),
        .pop   (dispatch),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_a, head_b, head_tag} = head;

    // The slot counts as free when it drains on this same edge.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign dispatch  = (state_q == IDLE) && !fifo_empty && slot_free;
    assign head_zero = (head_a == '0) || (head_b == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_r_q      <= '0;
            out_tag_q    <= '0;
            out_bypass_q <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
            tag_q        <= '0;
        end else begin
            eng_start_q <= 1'b0;
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (dispatch) begin
                        // The engine never terminates on a zero operand; gcd(x,0) = x.
                        if (head_zero) begin
                            out_valid_q  <= 1'b1;
                            out_r_q      <= head_a | head_b;
                            out_tag_q    <= head_tag;
                            out_bypass_q <= 1'b1;
                        end else begin
                            eng_a_q <= head_a;
                            eng_b_q <= head_b;
                            tag_q   <= head_tag;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.eng_ready) begin
                        eng_start_q <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.eng_done_tick) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Engine result carries its final shift only one cycle after done_tick.
                    out_valid_q  <= 1'b1;
                    out_r_q      <= bus.eng_r;
                    out_tag_q    <= tag_q;
                    out_bypass_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_r      = out_r_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_bypass = out_bypass_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_a      = eng_a_q;
    assign bus.eng_b      = eng_b_q;
    assign bus.busy       = !fifo_empty || (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb/tb_gcd_dispatch.sv - randomized and directed checks of gcd_dispatch against a job-level model
module tb_gcd_dispatch;
    import gcd_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int D  = 4;

    typedef struct {
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          byp;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gcd_dispatch_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    gcd_dispatch #(.WIDTH(W), .DEPTH(D), .TAG_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    gcd_job_t exp_q[$];
    gcd_job_t eng_q[$];
    res_t     obs_q[$];

    int   lat_force = 0;
    bit   eng_stall_en = 1'b0;
    int   n_starts = 0;
    int   done_cyc = 0;
    int   rise_cyc = 0;
    int   or_mode = 0;
    logic or_fixed = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] odd_part(input logic [W-1:0] g);
        logic [W-1:0] x = g;
        if (x == 0) return 0;
        while (x[0] == 1'b0) x = x >> 1;
        return x;
    endfunction

    // Engine: result lacks its power-of-two factor during done_tick, complete one cycle later.
    initial begin : engine
        int       phase;
        int       lat;
        logic [W-1:0] g;
        gcd_job_t j;
        phase = 0; lat = 0; g = '0;
        bus.eng_ready = 1'b1;
        bus.eng_done_tick = 1'b0;
        bus.eng_r = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                phase = 0;
                bus.eng_ready = 1'b1;
                bus.eng_done_tick = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (bus.eng_start) begin
                            n_starts++;
                            chk("start_while_ready", bus.eng_ready, 1);
                            if (eng_q.size() == 0) begin
                                chk("start_unexpected", bus.eng_start, 0);
                            end else begin
                                j = eng_q.pop_front();
                                chk("eng_a", bus.eng_a, j.a);
                                chk("eng_b", bus.eng_b, j.b);
                            end
                            g = gcd_ref(bus.eng_a, bus.eng_b);
                            lat = (lat_force > 0) ? lat_force : $urandom_range(0, 5);
                            bus.eng_ready = 1'b0;
                            phase = 1;
                        end else begin
                            bus.eng_ready = eng_stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                        end
                    end
                    1: begin
                        chk("start_one_pulse", bus.eng_start, 0);
                        if (lat == 0) begin
                            bus.eng_done_tick = 1'b1;
                            bus.eng_r = odd_part(g);
                            done_cyc = cyc;
                            phase = 2;
                        end else begin
                            lat--;
                        end
                    end
                    default: begin
                        chk("start_one_pulse", bus.eng_start, 0);
                        bus.eng_done_tick = 1'b0;
                        bus.eng_r = g;
                        bus.eng_ready = 1'b1;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin : out_ready_drv
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (or_mode)
                0:       bus.out_ready = or_fixed;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin : compare
        logic         pv, pr, p_byp;
        logic [W-1:0] p_r;
        logic [TW-1:0] p_tag;
        gcd_job_t     j;
        res_t         o;
        pv = 1'b0; pr = 1'b0; p_byp = 1'b0; p_r = '0; p_tag = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_r", bus.out_r, p_r);
                    chk("hold_tag", bus.out_tag, p_tag);
                    chk("hold_bypass", bus.out_bypass, p_byp);
                end
                if (bus.out_valid && !pv) rise_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", bus.out_valid, 0);
                    end else begin
                        j = exp_q.pop_front();
                        chk("out_r", bus.out_r, gcd_ref(j.a, j.b));
                        chk("out_tag", bus.out_tag, j.tag);
                        chk("out_bypass", bus.out_bypass, (j.a == 0) || (j.b == 0));
                    end
                    o.r = bus.out_r; o.tag = bus.out_tag; o.byp = bus.out_bypass;
                    obs_q.push_back(o);
                end
                pv = bus.out_valid; pr = bus.out_ready;
                p_r = bus.out_r; p_tag = bus.out_tag; p_byp = bus.out_bypass;
            end
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input int maxc, output bit acc);
        gcd_job_t j;
        j.a = a; j.b = b; j.tag = tag;
        bus.in_a = a; bus.in_b = b; bus.in_tag = tag; bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < maxc && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                exp_q.push_back(j);
                if (a != 0 && b != 0) eng_q.push_back(j);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int i = 0;
        while ((exp_q.size() != 0 || bus.busy) && i < maxc) begin
            @(posedge clk); #1;
            i++;
        end
        chk("results_pending", exp_q.size(), 0);
        chk("busy_after_drain", bus.busy, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, bus.in_ready, 1);
        chk({pfx, "_out_valid"}, bus.out_valid, 0);
        chk({pfx, "_out_r"}, bus.out_r, 0);
        chk({pfx, "_out_tag"}, bus.out_tag, 0);
        chk({pfx, "_out_bypass"}, bus.out_bypass, 0);
        chk({pfx, "_eng_start"}, bus.eng_start, 0);
        chk({pfx, "_eng_a"}, bus.eng_a, 0);
        chk({pfx, "_eng_b"}, bus.eng_b, 0);
        chk({pfx, "_busy"}, bus.busy, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit acc;
        int s0, n_acc;
        logic [W-1:0] a, b;
        int f, sel;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;

        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // (48,18): single start, result 6, out_valid two cycles after done_tick
        obs_q.delete(); s0 = n_starts;
        push(48, 18, 3, 20, acc);
        drain(200);
        chk("t1_count", obs_q.size(), 1);
        chk("t1_r", obs_q[0].r, 6);
        chk("t1_tag", obs_q[0].tag, 3);
        chk("t1_bypass", obs_q[0].byp, 0);
        chk("t1_starts", n_starts - s0, 1);
        chk("t1_eng_a_held", bus.eng_a, 48);
        chk("t1_eng_b_held", bus.eng_b, 18);
        chk("t1_done_to_valid", rise_cyc - done_cyc, 2);

        // (64,96): early capture would return 1
        obs_q.delete();
        push(64, 96, 1, 20, acc);
        drain(200);
        chk("t2_r", obs_q[0].r, 32);
        chk("t2_tag", obs_q[0].tag, 1);

        // zero operands bypass the engine
        obs_q.delete(); s0 = n_starts;
        push(0, 35, 2, 20, acc);
        push(0, 0, 5, 20, acc);
        drain(200);
        chk("t3_count", obs_q.size(), 2);
        chk("t3_r0", obs_q[0].r, 35);
        chk("t3_byp0", obs_q[0].byp, 1);
        chk("t3_tag0", obs_q[0].tag, 2);
        chk("t3_r1", obs_q[1].r, 0);
        chk("t3_byp1", obs_q[1].byp, 1);
        chk("t3_tag1", obs_q[1].tag, 5);
        chk("t3_starts", n_starts - s0, 0);

        // backpressure: one result in the slot plus DEPTH queued
        obs_q.delete();
        or_fixed = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            push(12, 8, k[TW-1:0], 40, acc);
            n_acc += int'(acc);
        end
        chk("t4_accepts", n_acc, 5);
        chk("t4_in_ready", bus.in_ready, 0);
        chk("t4_out_valid", bus.out_valid, 1);
        chk("t4_slot_tag", bus.out_tag, 0);
        or_fixed = 1'b1;
        drain(400);
        chk("t4_count", obs_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("t4_tag_order", obs_q[k].tag, k);
            chk("t4_r", obs_q[k].r, 4);
        end

        // reset while waiting on the engine with three jobs queued
        lat_force = 40;
        for (int k = 0; k < 4; k++) push(12, 8, 4'(8 + k), 20, acc);
        repeat (4) @(posedge clk); #1;
        chk("t5_busy_before", bus.busy, 1);
        chk("t5_in_ready_before", bus.in_ready, 1);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        exp_q.delete(); eng_q.delete();
        lat_force = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        repeat (30) @(posedge clk); #1;
        chk("t5_out_valid_after", bus.out_valid, 0);
        chk("t5_busy_after", bus.busy, 0);

        // mixed jobs with out_ready toggling every cycle
        obs_q.delete(); or_mode = 1;
        push(9, 6, 6, 20, acc);
        push(0, 7, 7, 20, acc);
        push(100, 75, 8, 20, acc);
        drain(400);
        chk("t6_count", obs_q.size(), 3);
        chk("t6_r0", obs_q[0].r, 3);
        chk("t6_r1", obs_q[1].r, 7);
        chk("t6_byp1", obs_q[1].byp, 1);
        chk("t6_r2", obs_q[2].r, 25);
        chk("t6_byp2", obs_q[2].byp, 0);

        // randomized traffic, consumer stalls and engine busy periods
        or_mode = 2; eng_stall_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            sel = $urandom_range(0, 11);
            f = $urandom_range(1, 64);
            a = W'(f * $urandom_range(1, 5000));
            b = W'(f * $urandom_range(1, 5000));
            case (sel)
                0: a = '0;
                1: b = '0;
                2: begin a = '0; b = '0; end
                3: begin a = $urandom; b = $urandom; end
                default: ;
            endcase
            push(a, b, TW'($urandom), 400, acc);
            if (!acc) chk("push_timeout", bus.in_ready, 1);
        end
        drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_dispatch.md
Name: gcd_dispatch

Overview:
- Upstream feeder and result collector for the binary GCD engine.
- Accepts tagged 32-bit operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one job at a time to the engine over its start/ready/done_tick interface, captures each result, and presents it in order on a valid/ready output stream.
- Resolves zero-operand jobs itself, because the engine never terminates when an operand is zero.

Parameters:
- WIDTH, 32: operand/result width; must match the engine.
- DEPTH, 4: input FIFO entries; power of 2, at least 2.
- TAG_W, 4: width of the job tag carried alongside each job.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset. The engine's active-high reset is driven by ~reset_n at integration.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  job tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_r  out  WIDTH  gcd result.
- out_tag  out  TAG_W  tag of the job that produced the result.
- out_bypass  out  1  result was produced without the engine (zero operand).
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a  out  WIDTH  engine a_in.
- eng_b  out  WIDTH  engine b_in.
- eng_ready  in  1  engine idle.
- eng_done_tick  in  1  engine completion pulse.
- eng_r  in  WIDTH  engine result.
- busy  out  1  FIFO non-empty, or state is not IDLE, or out_valid is high.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_r=0, out_tag=0, out_bypass=0, eng_start=0, eng_a=0, eng_b=0, FIFO empty, state=IDLE.
- Input side:
  - A push occurs on in_valid && in_ready.
  - in_ready = !full, derived from registered FIFO state only; no combinational path from out_ready or in_valid.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- Output slot is a single register:
  - out_valid, out_r, out_tag and out_bypass are held stable until out_valid && out_ready.
  - On that handshake the slot is freed the same edge.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - Acts when the FIFO is non-empty and the output slot is free, or is freed this cycle.
  - If head a==0 or b==0: pop; next edge load out_r=a|b, out_tag=tag, out_bypass=1, out_valid=1; stay in IDLE. gcd(0,0)=0. Latency is pop to out_valid in 1 cycle.
  - Otherwise: pop, latch eng_a/eng_b and the tag, go to ISSUE.
- ISSUE:
  - Hold eng_a/eng_b stable.
  - When eng_ready=1, assert eng_start for exactly one cycle and go to WAIT.
  - While eng_ready=0, wait with eng_start=0.
- WAIT:
  - On eng_done_tick, go to CAPTURE.
  - No timeout. Engine latency is data dependent and unbounded from this block's view.
- CAPTURE:
  - The engine's r is valid only on the cycle after done_tick, when the a<<n shift has been applied.
  - Load out_r=eng_r, out_tag=latched tag, out_bypass=0, out_valid=1; return to IDLE.
- Only one engine job is in flight at a time, so results leave in input order.
- The output slot is always free on entering CAPTURE, since issue requires it free and nothing else fills it meanwhile.
- eng_a/eng_b keep their last values outside ISSUE.
- Reset asserted mid-operation: all state is cleared immediately, and the in-flight job and all queued jobs are discarded. No result is emitted after reset deasserts.
- Widths: no arithmetic beyond the zero test and the OR; the FIFO count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package gcd_pkg holds:
  - the WIDTH default constant;
  - the dispatcher state enum (IDLE, ISSUE, WAIT, CAPTURE);
  - the job struct {a, b, tag}.
- One sub-module, gcd_job_fifo: a synchronous DEPTH-entry FIFO with full/empty flags, push/pop, same-cycle push+pop, and a first-word-fall-through head.

Test Plan:
- Push (48,18,tag 3) with out_ready=1 -> exactly one eng_start pulse with eng_a=48, eng_b=18; result out_r=6, out_tag=3, out_bypass=0; out_valid rises 2 cycles after eng_done_tick.
- Push (64,96,tag 1) -> out_r=32. Confirms capture happens on the cycle after done_tick (a 1-cycle-early capture returns 1).
- Push (0,35,tag 2), then (0,0,tag 5) -> out_r=35 with bypass=1 and eng_start never asserted; then out_r=0 with bypass=1.
- Backpressure, out_ready=0 with DEPTH=4: push 6 jobs of (12,8).
  - in_ready drops after 5 accepts: 1 job in the output slot and 4 in the FIFO.
  - Releasing out_ready drains results in tag order, all with out_r=4.
- Assert reset_n=0 while in WAIT with 3 jobs queued -> all outputs return to reset values asynchronously; after release, out_valid stays 0 and busy=0.
- Push a 3-job mix (9,6), (0,7), (100,75) with out_ready toggling every cycle -> outputs 3, 7 (bypass), 25 in order; each value held stable while out_ready=0.
